// File: rtl/mem_access_stage_if.sv
// Bundles the upstream request, downstream result and both valid/ready
// handshakes of mem_access_stage. The stage uses the slave view and its
// driver uses the master view.
interface mem_access_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SB_W   = 10
);
    // Upstream side
    logic              in_valid;
    logic              in_ready;
    logic              mem_read;
    logic              mem_write;
    logic              sp_sel;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] sp_addr;
    logic [DATA_W-1:0] write_data;
    logic [SB_W-1:0]   sb_in;

    // Downstream side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_out;
    logic [SB_W-1:0]   sb_out;
    logic              conflict;

    modport master (
        output in_valid, mem_read, mem_write, sp_sel, alu_result, sp_addr, write_data, sb_in,
        output out_ready,
        input  in_ready, out_valid, mem_data, alu_out, sb_out, conflict
    );

    modport slave (
        input  in_valid, mem_read, mem_write, sp_sel, alu_result, sp_addr, write_data, sb_in,
        input  out_ready,
        output in_ready, out_valid, mem_data, alu_out, sb_out, conflict
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between execute and write-back. Selects the
// data-memory address (zero-extended ALU result or stack pointer), performs a
// load or store on an internal word-addressed memory with optional wait
// states, and forwards the ALU result and sideband to write-back.
module mem_access_stage #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned SB_W        = 10
) (
    input logic                clk,
    input logic                rst_n,
    mem_access_stage_if.slave  bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam bit          HAS_WAIT = (WAIT_STATES != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    // Storage, deliberately without reset so contents survive rst_n
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Request parked while wait states elapse
    logic [IDX_W-1:0]  req_idx_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              req_write_q;
    logic              req_load_q;

    logic [DATA_W-1:0] mem_data_q;
    logic [DATA_W-1:0] alu_out_q;
    logic [SB_W-1:0]   sb_out_q;
    logic              conflict_q;

    logic [ADDR_W-1:0] eff_addr;
    logic [IDX_W-1:0]  idx;
    logic              in_ready;
    logic              accept;
    logic              is_mem;
    logic              is_load;
    logic              take_now;
    logic              take_wait;
    logic              commit;
    logic              mem_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic              acc_load;
    logic              unused_addr;

    // Address bits above the memory index are ignored, so addresses wrap
    assign eff_addr    = bus.sp_sel ? bus.sp_addr : ADDR_W'(bus.alu_result);
    assign idx         = eff_addr[IDX_W-1:0];
    assign unused_addr = ^eff_addr[ADDR_W-1:IDX_W];

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
    assign accept    = bus.in_valid & in_ready;
    assign is_mem    = bus.mem_read | bus.mem_write;
    // Read+write together is treated as a store
    assign is_load   = bus.mem_read & ~bus.mem_write;
    assign take_now  = accept & (~is_mem | ~HAS_WAIT);
    assign take_wait = accept & is_mem & HAS_WAIT;
    assign commit    = (state_q == ST_WAIT) & (cnt_q == 4'd1);

    // commit and take_now are exclusive: no accept happens while in WAIT
    assign acc_idx   = commit ? req_idx_q   : idx;
    assign mem_wdata = commit ? req_wdata_q : bus.write_data;
    assign acc_load  = commit ? req_load_q  : is_load;
    // Gated by rst_n so nothing presented during reset can reach the array
    assign mem_we    = rst_n & (commit ? req_write_q : (take_now & bus.mem_write));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.mem_data  = mem_data_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.sb_out    = sb_out_q;
    assign bus.conflict  = conflict_q;

    // Next-state: DONE with out_ready behaves like IDLE in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                state_d = ST_DONE;
                cnt_d   = 4'd0;
            end
        end else if (in_ready) begin
            if (take_wait) begin
                state_d = ST_WAIT;
                cnt_d   = WS;
            end else if (take_now) begin
                state_d = ST_DONE;
            end else if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Park a memory request that must sit out its wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_idx_q   <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            req_load_q  <= 1'b0;
        end else if (take_wait) begin
            req_idx_q   <= idx;
            req_wdata_q <= bus.write_data;
            req_write_q <= bus.mem_write;
            req_load_q  <= is_load;
        end
    end

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= mem_wdata;
        end
    end

    // Result registers: sideband at accept, load data at the access edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_q <= '0;
            alu_out_q  <= '0;
            sb_out_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (take_now | take_wait) begin
                alu_out_q  <= bus.alu_result;
                sb_out_q   <= bus.sb_in;
                conflict_q <= bus.mem_read & bus.mem_write;
            end
            if (take_now | commit) begin
                mem_data_q <= acc_load ? mem_q[acc_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a table of back-to-back transactions, random
// traffic against a one-slot transaction model, and hand-written sequences
// for wait states, backpressure and reset during a pending store.
module tb_mem_access_stage;

    logic clk;
    logic rst_n;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    mem_access_stage_if b0 ();
    mem_access_stage_if b2 ();
    mem_access_stage_if b3 ();

    mem_access_stage #(.WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mem_access_stage #(.WAIT_STATES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mem_access_stage #(.WAIT_STATES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        sp;
        logic [15:0] alu;
        logic [31:0] spa;
        logic [15:0] wd;
        logic [9:0]  sb;
        logic [15:0] exp_mem;
        logic        exp_conf;
    } vec_t;

    vec_t vecs [10];

    logic [15:0] model_mem [1024];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic rd, input logic wr, input logic sp,
                          input logic [15:0] alu, input logic [31:0] spa,
                          input logic [15:0] wd, input logic [9:0] sb);
        b0.in_valid = v; b0.mem_read = rd; b0.mem_write = wr; b0.sp_sel = sp;
        b0.alu_result = alu; b0.sp_addr = spa; b0.write_data = wd; b0.sb_in = sb;
    endtask

    task automatic idle_all();
        b0.in_valid = 0; b0.mem_read = 0; b0.mem_write = 0; b0.sp_sel = 0;
        b0.alu_result = 0; b0.sp_addr = 0; b0.write_data = 0; b0.sb_in = 0; b0.out_ready = 1;
        b2.in_valid = 0; b2.mem_read = 0; b2.mem_write = 0; b2.sp_sel = 0;
        b2.alu_result = 0; b2.sp_addr = 0; b2.write_data = 0; b2.sb_in = 0; b2.out_ready = 1;
        b3.in_valid = 0; b3.mem_read = 0; b3.mem_write = 0; b3.sp_sel = 0;
        b3.alu_result = 0; b3.sp_addr = 0; b3.write_data = 0; b3.sb_in = 0; b3.out_ready = 1;
    endtask

    // Counts cycles after an accept edge until out_valid; in_ready must stay low meanwhile
    task automatic wait_valid3(input string name, output int n);
        n = 1;
        while (!b3.out_valid && n < 20) begin
            chk({name, "_in_ready_low"}, b3.in_ready, 1'b0);
            tick();
            n++;
        end
    endtask

    task automatic wait_valid2(output int n);
        n = 1;
        while (!b2.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic        m_ov;
        logic [15:0] m_mem, m_alu;
        logic [9:0]  m_sb;
        logic        m_conf;
        logic        exp_ready;

        idle_all();
        rst_n = 0;
        #12;
        chk("reset_u0", {b0.out_valid, b0.in_ready, b0.mem_data, b0.alu_out, b0.sb_out, b0.conflict},
            {1'b0, 1'b1, 16'h0, 16'h0, 10'h0, 1'b0});
        chk("reset_u2", {b2.out_valid, b2.in_ready, b2.mem_data, b2.alu_out, b2.sb_out, b2.conflict},
            {1'b0, 1'b1, 16'h0, 16'h0, 10'h0, 1'b0});
        chk("reset_u3", {b3.out_valid, b3.in_ready, b3.mem_data, b3.alu_out, b3.sb_out, b3.conflict},
            {1'b0, 1'b1, 16'h0, 16'h0, 10'h0, 1'b0});
        rst_n = 1;
        tick();

        // ---------------- Back-to-back table, zero wait states ----------------
        //            rd    wr    sp    alu       spa            wd        sb       mem       conf
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,         16'h1234, 10'h001, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0010, 32'h0,         16'h0000, 10'h002, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0ABC, 32'h0000_03FF, 16'hA5A5, 10'h3FF, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0001, 32'h0000_07FF, 16'h0000, 10'h155, 16'hA5A5, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0007, 32'h0,         16'h00FF, 10'h2AA, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0007, 32'h0,         16'h0000, 10'h0F0, 16'h00FF, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0,         16'h9999, 10'h00F, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0410, 32'h0,         16'h0000, 10'h300, 16'h1234, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 16'h0000, 32'hFFFF_FC07, 16'h0000, 10'h0C3, 16'h00FF, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h0,         16'h0000, 10'h111, 16'hA5A5, 1'b0};

        b0.out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            drive0(1'b1, vecs[i].rd, vecs[i].wr, vecs[i].sp, vecs[i].alu, vecs[i].spa,
                   vecs[i].wd, vecs[i].sb);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), b0.in_ready, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_result", i),
                {b0.out_valid, b0.mem_data, b0.conflict, b0.alu_out, b0.sb_out},
                {1'b1, vecs[i].exp_mem, vecs[i].exp_conf, vecs[i].alu, vecs[i].sb});
        end

        // ---------------- Random traffic against a one-slot model ----------------
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = 16'(i * 37 + 5);
            drive0(1'b1, 1'b0, 1'b1, 1'b0, 16'(i), 32'h0, 16'(i * 37 + 5), 10'h0);
            tick();
        end
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 10'h0);
        tick();
        m_ov = 0; m_mem = 0; m_alu = 0; m_sb = 0; m_conf = 0;

        for (int c = 0; c < 400; c++) begin
            int          kind, ix;
            logic        rv, rr, rd, wr, sp;
            logic [15:0] alu, wd;
            logic [31:0] spa, addr;
            logic [9:0]  sb;
            int unsigned a;
            rv   = ($urandom_range(0, 3) != 0);
            rr   = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 3);
            rd   = (kind == 0) || (kind == 3);
            wr   = (kind == 1) || (kind == 3);
            sp   = 1'($urandom_range(0, 1));
            ix   = $urandom_range(0, 63);
            spa  = ($urandom() & 32'hFFFF_FC00) | 32'(ix);
            alu  = sp ? 16'($urandom()) : 16'(($urandom() & 32'h0000_FC00) | 32'(ix));
            wd   = 16'($urandom());
            sb   = 10'($urandom());
            drive0(rv, rd, wr, sp, alu, spa, wd, sb);
            b0.out_ready = rr;
            #1;
            exp_ready = !m_ov || rr;
            chk("rand_in_ready", b0.in_ready, exp_ready);
            if (m_ov && rr) m_ov = 0;
            if (rv && exp_ready) begin
                addr = sp ? spa : {16'h0, alu};
                a    = addr % 1024;
                if (wr) model_mem[a] = wd;
                m_mem  = (rd && !wr) ? model_mem[a] : 16'h0;
                m_alu  = alu;
                m_sb   = sb;
                m_conf = rd && wr;
                m_ov   = 1;
            end
            @(posedge clk);
            #1;
            chk("rand_out_valid", b0.out_valid, m_ov);
            if (m_ov)
                chk("rand_result", {b0.mem_data, b0.alu_out, b0.sb_out, b0.conflict},
                    {m_mem, m_alu, m_sb, m_conf});
        end
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 10'h0);
        b0.out_ready = 1;
        tick();

        // ---------------- Wait states and backpressure, WAIT_STATES=3 ----------------
        b3.out_ready = 0;
        b3.in_valid = 1; b3.mem_write = 1; b3.mem_read = 0; b3.alu_result = 16'd20;
        b3.write_data = 16'h5A5A; b3.sb_in = 10'h155;
        tick();
        b3.in_valid = 0; b3.mem_write = 0;
        b3.write_data = 16'hDEAD; b3.alu_result = 16'h0999; b3.sb_in = 10'h000;
        wait_valid3("store", n);
        chk("store_latency", n, 4);
        for (int i = 0; i < 5; i++) begin
            chk("hold_stable", {b3.out_valid, b3.in_ready, b3.mem_data, b3.alu_out, b3.sb_out, b3.conflict},
                {1'b1, 1'b0, 16'h0, 16'd20, 10'h155, 1'b0});
            tick();
        end
        b3.in_valid = 1; b3.mem_read = 1; b3.alu_result = 16'd20; b3.sb_in = 10'h0AA;
        b3.out_ready = 1;
        #1;
        chk("ready_on_out_ready", b3.in_ready, 1'b1);
        @(posedge clk);
        #1;
        // Pass-through queued behind the load
        b3.mem_read = 0; b3.alu_result = 16'h0077; b3.sb_in = 10'h03C;
        wait_valid3("load", n);
        chk("load_latency", n, 4);
        chk("load_result", {b3.mem_data, b3.alu_out, b3.sb_out, b3.conflict},
            {16'h5A5A, 16'd20, 10'h0AA, 1'b0});
        chk("done_accepts", b3.in_ready, 1'b1);
        tick();
        b3.in_valid = 0;
        chk("queued_pass", {b3.out_valid, b3.mem_data, b3.alu_out, b3.sb_out},
            {1'b1, 16'h0, 16'h0077, 10'h03C});
        tick();
        chk("back_to_idle", b3.out_valid, 1'b0);

        // ---------------- Reset during WAIT, WAIT_STATES=2 ----------------
        b2.in_valid = 1; b2.mem_write = 1; b2.alu_result = 16'd5; b2.write_data = 16'h1111;
        b2.sb_in = 10'h001;
        tick();
        b2.in_valid = 0; b2.mem_write = 0;
        wait_valid2(n);
        chk("pre_store_latency", n, 3);
        tick();
        b2.in_valid = 1; b2.mem_write = 1; b2.alu_result = 16'd5; b2.write_data = 16'hBEEF;
        b2.sb_in = 10'h2F0;
        tick();
        b2.in_valid = 0; b2.mem_write = 0;
        chk("in_wait_before_reset", {b2.out_valid, b2.in_ready}, 2'b00);
        rst_n = 0;
        #2;
        chk("reset_mid_wait", {b2.out_valid, b2.mem_data, b2.alu_out, b2.sb_out, b2.conflict},
            {1'b0, 16'h0, 16'h0, 10'h0, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1;
        tick();
        tick();
        b2.in_valid = 1; b2.mem_read = 1; b2.alu_result = 16'd5; b2.sb_in = 10'h0F0;
        tick();
        b2.in_valid = 0; b2.mem_read = 0;
        wait_valid2(n);
        chk("post_reset_latency", n, 3);
        chk("no_commit_after_reset", {b2.mem_data, b2.sb_out}, {16'h1111, 10'h0F0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised, registered memory-access pipeline stage for the RISC datapath, sitting between execute and write-back. It selects the data-memory address from either the zero-extended ALU result or the stack pointer, and performs a read or write to an internal word-addressed data memory with a configurable number of wait states. It carries write-back sideband fields through unchanged, and uses valid/ready handshakes on both sides so that upstream and downstream stalls propagate correctly.

## Interface
- DATA_W, 16, data word and ALU-result width
- ADDR_W, 32, address width (stack pointer width)
- DEPTH, 1024, memory depth in words (power of two)
- WAIT_STATES, 0, extra cycles per memory access (0..15)
- SB_W, 10, sideband width (dest regs, WB control, flags), passed through untouched

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream transaction present
- in_ready  output  1  stage can accept this cycle
- mem_read  input  1  load
- mem_write  input  1  store
- sp_sel  input  1  address from sp_addr (push/pop/call/ret), else from alu_result
- alu_result  input  DATA_W  ALU result; also the address source when sp_sel=0
- sp_addr  input  ADDR_W  stack-pointer address
- write_data  input  DATA_W  store data
- sb_in  input  SB_W  sideband
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts
- mem_data  output  DATA_W  load data; 0 for non-loads
- alu_out  output  DATA_W  registered alu_result
- sb_out  output  SB_W  registered sb_in
- conflict  output  1  accepted transaction had mem_read and mem_write both set

## Operation
- Accept condition: in_valid & in_ready.
- Effective address: sp_sel ? sp_addr : {zeros, alu_result}. The index is the low log2(DEPTH) bits; higher bits are ignored, so out-of-range addresses wrap.
- Internal memory: DEPTH x DATA_W array with no reset. Writes are synchronous. Reads are registered into mem_data.
- Transaction classes:
  - Memory op: mem_read | mem_write.
  - Pass-through op: neither signal set.
- mem_read & mem_write both set: treated as a write. mem_data is 0 and conflict=1 for that result.
- FSM:
  - IDLE: in_ready=1. On accept of a pass-through op, or of a memory op with WAIT_STATES=0: perform the access at this edge, latch outputs, go to DONE. On accept of a memory op with WAIT_STATES>0: latch the request, load cnt=WAIT_STATES, go to WAIT.
  - WAIT: in_ready=0, out_valid=0, cnt decrements each cycle. In the cycle where cnt==1: commit the write or capture the read, go to DONE.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0. When out_ready=1, the stage behaves as IDLE in the same cycle: in_ready=1, and an acceptance follows the IDLE rules. With no acceptance, go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Writes commit exactly once per accepted store, never while held in DONE.

## Timing
- Reset (async on rst_n low):
  - state=IDLE, cnt=0.
  - out_valid=0, mem_data=0, alu_out=0, sb_out=0, conflict=0.
  - Memory contents are unchanged.
- Reset during WAIT abandons the request; a pending store never commits.
- Latency from accept edge to out_valid high:
  - Pass-through op: 1 cycle.
  - Memory op: 1+WAIT_STATES cycles.
- Throughput: one transaction per cycle when WAIT_STATES=0 or for pass-through ops, with out_ready held high.
- Read-after-write to the same address on consecutive transactions: the load returns the newly stored value, since the store commits before the load's access edge.
- Outputs change only at the accept/commit edge. They are stable for the entire period out_valid=1 & out_ready=0.

## Test plan
- Reset: assert rst_n=0 mid-WAIT with a store of 0xBEEF to address 5 (WAIT_STATES=2), then release. Required: out_valid=0 and all outputs 0; a subsequent load of address 5 does not return 0xBEEF.
- Store then load, WAIT_STATES=0:
  - Stimulus: store 0x1234 at alu_result=0x0010, then load alu_result=0x0010 back-to-back, out_ready=1.
  - Required: mem_data=0x1234 on the second result, in_ready never drops.
- Stack path: sp_sel=1, sp_addr=0x0000_03FF, store 0xA5A5, then load with sp_addr=0x0000_07FF (DEPTH=1024). Required: the load returns 0xA5A5 (address wrap).
- Wait states, WAIT_STATES=3, load:
  - Required: out_valid rises exactly 4 cycles after accept, and in_ready=0 during WAIT.
  - A pass-through op queued behind it is accepted only in the DONE cycle.
- Backpressure: hold out_ready=0 for 5 cycles while in DONE after a store.
  - Required: outputs stable, in_ready=0, memory written once. Verify with a later load.
  - The next transaction is accepted on the cycle out_ready rises.
- Conflict: mem_read=mem_write=1, write_data=0x00FF, address 7. Required: conflict=1, mem_data=0; a later load of 7 returns 0x00FF. sb_out equals sb_in throughout.
